// File: rtl/multi_obstacle_logic.sv
// Game-state and collision engine for flappy: checks NUM_PIPES pipes plus the floor every cycle,
// scores pipes the bird has cleared and tracks the best score since reset.
module multi_obstacle_logic #(
    parameter int NUM_PIPES = 4,
    parameter int COORD_W   = 10,
    parameter int MARGIN    = 0,
    parameter int LOSE_HOLD = 1600,
    parameter int SCORE_W   = 8,
    localparam int IDX_W    = $clog2(NUM_PIPES + 1)
) (
    input  logic                           Clk,
    input  logic                           reset_n,
    input  logic                           Start,
    input  logic                           Ack,
    input  logic [COORD_W-1:0]             Bird_X_L,
    input  logic [COORD_W-1:0]             Bird_X_R,
    input  logic [COORD_W-1:0]             Bird_Y_T,
    input  logic [COORD_W-1:0]             Bird_Y_B,
    input  logic [NUM_PIPES*COORD_W-1:0]   Pipe_X_L,
    input  logic [NUM_PIPES*COORD_W-1:0]   Pipe_X_R,
    input  logic [NUM_PIPES*COORD_W-1:0]   Gap_Y_T,
    input  logic [NUM_PIPES*COORD_W-1:0]   Gap_Y_B,
    input  logic [NUM_PIPES-1:0]           Pipe_Valid,
    input  logic [COORD_W-1:0]             Floor_Y,
    output logic                           Q_Initial,
    output logic                           Q_Check,
    output logic                           Q_Lose,
    output logic [SCORE_W-1:0]             Score,
    output logic [SCORE_W-1:0]             High_Score,
    output logic                           Score_Pulse,
    output logic [IDX_W-1:0]               Hit_Idx
);

    localparam int AW    = COORD_W + 1;
    localparam int CNT_W = $clog2(LOSE_HOLD + 1);
    localparam int SUM_W = SCORE_W + IDX_W;
    localparam logic [AW-1:0]      MARGIN_V  = AW'(MARGIN);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [CNT_W-1:0]   HOLD_V    = CNT_W'(LOSE_HOLD);

    typedef enum logic [2:0] {
        Q_INITIAL = 3'b001,
        Q_CHECK   = 3'b010,
        Q_LOSE    = 3'b100
    } state_t;

    state_t state, state_nxt;

    logic [SCORE_W-1:0]   score, high_score;
    logic                 score_pulse;
    logic                 hit_r;
    logic [IDX_W-1:0]     hit_idx;
    logic [NUM_PIPES-1:0] passed;
    logic [CNT_W-1:0]     lose_cnt;

    logic [COORD_W-1:0]   pxl [NUM_PIPES];
    logic [COORD_W-1:0]   pxr [NUM_PIPES];
    logic [COORD_W-1:0]   gyt [NUM_PIPES];
    logic [COORD_W-1:0]   gyb [NUM_PIPES];

    logic [AW-1:0]        bxl, bxr, byt, byb;
    logic [NUM_PIPES-1:0] hit, pass, passed_nxt;
    logic                 hit_floor, any_hit, count_en;
    logic [IDX_W-1:0]     hit_idx_c, pass_cnt;
    logic [SUM_W-1:0]     score_sum;
    logic [SCORE_W-1:0]   score_nxt;

    // Near edges grow by the margin, far edges shrink and clamp at zero instead of wrapping.
    function automatic logic [AW-1:0] shrink_lo(input logic [COORD_W-1:0] v);
        return AW'(v) + MARGIN_V;
    endfunction

    function automatic logic [AW-1:0] shrink_hi(input logic [COORD_W-1:0] v);
        return (AW'(v) >= MARGIN_V) ? AW'(v) - MARGIN_V : '0;
    endfunction

    assign bxl = shrink_lo(Bird_X_L);
    assign bxr = shrink_hi(Bird_X_R);
    assign byt = shrink_lo(Bird_Y_T);
    assign byb = shrink_hi(Bird_Y_B);

    always_comb begin
        for (int i = 0; i < NUM_PIPES; i++) begin
            pxl[i] = Pipe_X_L[i*COORD_W +: COORD_W];
            pxr[i] = Pipe_X_R[i*COORD_W +: COORD_W];
            gyt[i] = Gap_Y_T[i*COORD_W +: COORD_W];
            gyb[i] = Gap_Y_B[i*COORD_W +: COORD_W];
        end
    end

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        hit        = '0;
        pass       = '0;
        passed_nxt = '0;
        pass_cnt   = '0;
        hit_idx_c  = IDX_W'(NUM_PIPES);
        hit_floor  = (byb >= AW'(Floor_Y));
        for (int i = 0; i < NUM_PIPES; i++) begin
            hit[i] = Pipe_Valid[i] && (bxr > AW'(pxl[i])) && (bxl < AW'(pxr[i])) &&
                     ((byt <= AW'(gyt[i])) || (byb >= AW'(gyb[i])));
        end
        for (int i = NUM_PIPES - 1; i >= 0; i--) begin
            if (hit[i]) hit_idx_c = IDX_W'(i);
        end
        any_hit  = (|hit) || hit_floor;
        count_en = !hit_r && !any_hit;
        for (int i = 0; i < NUM_PIPES; i++) begin
            pass[i]       = Pipe_Valid[i] && !passed[i] && (Bird_X_L > pxr[i]) && count_en;
            passed_nxt[i] = Pipe_Valid[i] && (Bird_X_L > pxr[i]) && (passed[i] || count_en);
            pass_cnt      = pass_cnt + IDX_W'(pass[i]);
        end
        score_sum = SUM_W'(score) + SUM_W'(pass_cnt);
        score_nxt = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) state <= Q_INITIAL;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            Q_INITIAL: if (Start) state_nxt = Q_CHECK;
            Q_CHECK:   if (hit_r) state_nxt = Q_LOSE;
            Q_LOSE:    if (Ack && (lose_cnt >= HOLD_V)) state_nxt = Q_INITIAL;
            default:   state_nxt = Q_INITIAL;
        endcase
    end

    // NOTE: the small passed[] vector is reset with everything else; it gates scoring right after reset.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            score       <= '0;
            high_score  <= '0;
            score_pulse <= 1'b0;
            hit_r       <= 1'b0;
            hit_idx     <= '0;
            passed      <= '0;
            lose_cnt    <= '0;
        end else begin
            score_pulse <= 1'b0;
            lose_cnt    <= '0;
            case (state)
                Q_INITIAL: begin
                    if (Start) begin
                        score  <= '0;
                        passed <= '0;
                        hit_r  <= 1'b0;
                    end
                end
                Q_CHECK: begin
                    if (!hit_r && any_hit) begin
                        hit_r   <= 1'b1;
                        hit_idx <= hit_idx_c;
                    end
                    if (hit_r && (score > high_score)) high_score <= score;
                    passed      <= passed_nxt;
                    score       <= score_nxt;
                    score_pulse <= (score_nxt != score);
                end
                Q_LOSE: begin
                    if (state_nxt == Q_LOSE)
                        lose_cnt <= (lose_cnt < HOLD_V) ? lose_cnt + 1'b1 : lose_cnt;
                end
                default: ;
            endcase
        end
    end

    assign Q_Initial   = (state == Q_INITIAL);
    assign Q_Check     = (state == Q_CHECK);
    assign Q_Lose      = (state == Q_LOSE);
    assign Score       = score;
    assign High_Score  = high_score;
    assign Score_Pulse = score_pulse;
    assign Hit_Idx     = hit_idx;

endmodule
